// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: turns received byte frames into register-bus reads and
// writes, and supplies the next byte the SPI slave shifts out on miso.
module spi_cmd_ctrl #(
    parameter int          ADDR_W  = 7,
    parameter logic [7:0]  IDLE_TX = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ssel_active,
    input  logic              i_ssel_endmessage,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_byte,
    output logic [7:0]        o_tx_byte,
    output logic              o_tx_load,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [7:0]        o_reg_wdata,
    output logic              o_reg_we,
    output logic              o_reg_re,
    input  logic [7:0]        i_reg_rdata,
    output logic              o_busy,
    output logic              o_frame_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_WR      = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_CAP  = 3'd4;
    localparam logic [2:0] S_RD_WAIT = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic              r_ssel_prev;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_tx_byte;
    logic              r_tx_load;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [7:0]        r_reg_wdata;
    logic              r_reg_we;
    logic              r_reg_re;
    logic              r_frame_err;

    logic              w_frame_end;
    logic              w_ssel_rise;
    logic              w_cmd_rw;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_frame_end = i_ssel_endmessage | ~i_ssel_active;
    assign w_ssel_rise = i_ssel_active & ~r_ssel_prev;
    assign w_cmd_rw    = i_rx_byte[7];
    assign w_cmd_addr  = i_rx_byte[ADDR_W-1:0];
    assign w_addr_inc  = r_addr + ADDR_W'(1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ssel_rise) w_state_next = S_CMD;
            end
            S_CMD: begin
                if (w_frame_end)     w_state_next = S_IDLE;
                else if (i_rx_valid) w_state_next = w_cmd_rw ? S_WR : S_RD_REQ;
            end
            S_WR: begin
                if (w_frame_end) w_state_next = S_IDLE;
            end
            S_RD_REQ: begin
                w_state_next = w_frame_end ? S_IDLE : S_RD_CAP;
            end
            S_RD_CAP: begin
                w_state_next = w_frame_end ? S_IDLE : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_frame_end)     w_state_next = S_IDLE;
                else if (i_rx_valid) w_state_next = S_RD_REQ;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ssel_prev <= 1'b0;
            r_addr      <= '0;
            r_tx_byte   <= IDLE_TX;
            r_tx_load   <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ssel_prev <= i_ssel_active;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_tx_load   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ssel_rise) begin
                        r_tx_byte <= IDLE_TX;
                        r_tx_load <= 1'b1;
                    end
                end
                S_CMD: begin
                    // A command byte coinciding with frame end is dropped, not executed.
                    if (w_frame_end) begin
                        r_frame_err <= 1'b1;
                    end else if (i_rx_valid) begin
                        r_addr <= w_cmd_addr;
                        if (!w_cmd_rw) begin
                            r_reg_addr <= w_cmd_addr;
                            r_reg_re   <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (i_rx_valid) begin
                        r_reg_we    <= 1'b1;
                        r_reg_wdata <= i_rx_byte;
                        r_reg_addr  <= r_addr;
                        r_addr      <= w_addr_inc;
                    end
                end
                S_RD_CAP: begin
                    // Read data arrives one cycle after the strobe; drop it if the frame closed.
                    if (!w_frame_end) begin
                        r_tx_byte <= i_reg_rdata;
                        r_tx_load <= 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (i_rx_valid && !w_frame_end) begin
                        r_addr     <= w_addr_inc;
                        r_reg_addr <= w_addr_inc;
                        r_reg_re   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx_byte   = r_tx_byte;
    assign o_tx_load   = r_tx_load;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_we    = r_reg_we;
    assign o_reg_re    = r_reg_re;
    assign o_busy      = (r_state != S_IDLE);
    assign o_frame_err = r_frame_err;

endmodule
